// File: rtl/fp16_uint8_stream_packer_pkg.sv
// rtl/fp16_uint8_stream_packer_pkg.sv - fp16 field layout, conversion classes and packed word type
package fp16_uint8_stream_packer_pkg;

  localparam int FP_EXP_W     = 5;
  localparam int FP_FRAC_W    = 10;
  localparam int FP_BIAS      = 15;
  localparam int PACK_DEFAULT = 4;

  localparam logic [FP_EXP_W-1:0]  FP_EXP_ALL1 = '1;
  // Exponent of the binade [128, 256); anything at or above 255.5 saturates.
  localparam logic [FP_EXP_W-1:0]  FP_EXP_128  = FP_EXP_W'(FP_BIAS + 7);
  localparam logic [FP_FRAC_W-1:0] FP_FRAC_SAT = 10'h3FC;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_SAT,
    CLS_NORM
  } fp_class_e;

  typedef struct packed {
    logic                        sof;
    logic                        eol;
    logic [8*PACK_DEFAULT-1:0]   data;
  } packed_word_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, write at full accepted when a read happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_INC;
      if (do_rd) rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fp16_uint8_stream_packer.sv
// rtl/fp16_uint8_stream_packer.sv - fp16 pixels to uint8, packed PACK per word by column, buffered in a FIFO
module fp16_uint8_stream_packer
  import fp16_uint8_stream_packer_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 400,
  parameter int PACK         = PACK_DEFAULT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       fp_i,
  input  logic [15:0]       col_i,
  input  logic [15:0]       row_i,
  input  logic              valid_i,
  output logic [8*PACK-1:0] data_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overflow_o
);

  localparam int LANE_W = $clog2(PACK);
  localparam int WORD_W = 8*PACK + 2;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  // Stage 1: field decode and classification
  logic                 pix_ok;
  logic                 fp_sign;
  logic [FP_EXP_W-1:0]  fp_exp;
  logic [FP_FRAC_W-1:0] fp_frac;
  fp_class_e            cls_d;
  logic [4:0]           shift_d;

  logic                 s1_valid;
  fp_class_e            s1_cls;
  logic [4:0]           s1_shift;
  logic [FP_FRAC_W-1:0] s1_frac;
  logic [15:0]          s1_col;
  logic [15:0]          s1_row;

  assign pix_ok  = valid_i && (col_i < 16'(IMAGE_WIDTH)) && (row_i < 16'(IMAGE_HEIGHT));
  assign fp_sign = fp_i[15];
  assign fp_exp  = fp_i[FP_FRAC_W +: FP_EXP_W];
  assign fp_frac = fp_i[FP_FRAC_W-1:0];
  assign shift_d = FP_EXP_128 - fp_exp;

  always_comb begin
    cls_d = CLS_NORM;
    if (fp_sign || fp_exp == '0 || (fp_exp == FP_EXP_ALL1 && fp_frac != '0)) begin
      cls_d = CLS_ZERO;
    end else if (fp_exp == FP_EXP_ALL1 || fp_exp > FP_EXP_128 ||
                 (fp_exp == FP_EXP_128 && fp_frac >= FP_FRAC_SAT)) begin
      cls_d = CLS_SAT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) s1_valid <= 1'b0;
    else       s1_valid <= pix_ok;
    s1_cls   <= cls_d;
    s1_shift <= shift_d;
    s1_frac  <= fp_frac;
    s1_col   <= col_i;
    s1_row   <= row_i;
  end

  // Stage 2: value * 2^24 is exact in 32 bits for every normal, non-saturating input
  logic [FP_FRAC_W:0] mant;
  logic [31:0]        scaled;
  logic [7:0]         int_part;
  logic               round_up;
  logic [7:0]         byte_d;

  logic               s2_valid;
  logic [7:0]         s2_byte;
  logic [15:0]        s2_col;
  logic [15:0]        s2_row;

  assign mant     = {1'b1, s1_frac};
  assign scaled   = {mant, 21'd0} >> s1_shift;
  assign int_part = scaled[31:24];
  assign round_up = scaled[23] && ((|scaled[22:0]) || scaled[24]);

  always_comb begin
    byte_d = int_part + {7'd0, round_up};
    case (s1_cls)
      CLS_ZERO: byte_d = 8'h00;
      CLS_SAT:  byte_d = 8'hFF;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) s2_valid <= 1'b0;
    else       s2_valid <= s1_valid;
    s2_byte <= byte_d;
    s2_col  <= s1_col;
    s2_row  <= s1_row;
  end

  // Word assembly: lane chosen by the pixel's own column so input gaps never skew packing
  logic [LANE_W-1:0] lane;
  logic [8*PACK-1:0] asm_q;
  logic [8*PACK-1:0] asm_next;
  logic              word_done;
  logic              word_sof;
  logic              word_eol;

  assign lane     = LANE_W'(s2_col % 16'(PACK));
  assign word_sof = (s2_row == 16'd0) && (s2_col == 16'(PACK - 1));
  assign word_eol = (s2_col == 16'(IMAGE_WIDTH - 1));

  always_comb begin
    asm_next  = asm_q;
    word_done = 1'b0;
    if (s2_valid) begin
      if (lane == '0) asm_next = '0;
      asm_next[lane*8 +: 8] = s2_byte;
      word_done = (lane == LAST_LANE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) asm_q <= '0;
    else       asm_q <= asm_next;
  end

  // Output buffer
  logic              rd_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rd_data;
  logic              overflow_q;

  assign rd_en = ready_i && !rst_i;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (word_done),
    .wr_data ({word_sof, word_eol, asm_next}),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (word_done && fifo_full && !(rd_en && !fifo_empty)) begin
      overflow_q <= 1'b1;
    end
  end

  assign valid_o    = !fifo_empty && !rst_i;
  assign overflow_o = overflow_q && !rst_i;
  assign {sof_o, eol_o, data_o} = valid_o ? fifo_rd_data : '0;

endmodule

// File: tb/tb_fp16_uint8_stream_packer.sv
// tb/tb_fp16_uint8_stream_packer.sv - randomized self-checking bench against a real-arithmetic reference model
module tb_fp16_uint8_stream_packer;

  localparam int W = 8;
  localparam int H = 2;
  localparam int P = 4;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] fp_i;
  logic [15:0] col_i;
  logic [15:0] row_i;
  logic        valid_i;
  logic [31:0] data_o;
  logic        sof_o;
  logic        eol_o;
  logic        valid_o;
  logic        ready_i;
  logic        overflow_o;

  always #5 clk = ~clk;

  fp16_uint8_stream_packer #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .PACK         (P),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .fp_i       (fp_i),
    .col_i      (col_i),
    .row_i      (row_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .sof_o      (sof_o),
    .eol_o      (eol_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  logic [33:0] gl_q[$];
  logic [15:0] fr[H][W];

  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) got_q.push_back({sof_o, eol_o, data_o});
  end

  function automatic logic [7:0] ref_conv(input logic [15:0] h);
    int  e;
    int  f;
    real v;
    real fl;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (h[15] || e == 0) return 8'h00;
    if (e == 31) return (f == 0) ? 8'hFF : 8'h00;
    v = real'(1024 + f) / 33554432.0;
    for (int i = 0; i < e; i++) v = v * 2.0;
    if (v >= 255.5) return 8'hFF;
    fl = $floor(v);
    if ((v - fl > 0.5) || (v - fl == 0.5 && int'(fl) % 2 == 1)) fl = fl + 1.0;
    return 8'(int'(fl));
  endfunction

  function automatic logic [33:0] exp_word(input int r, input int g);
    logic [31:0] d;
    for (int k = 0; k < P; k++) d[8*k +: 8] = ref_conv(fr[r][g*P + k]);
    return {(r == 0 && g == 0), (g*P + P - 1 == W - 1), d};
  endfunction

  task automatic push_frame_exp();
    for (int r = 0; r < H; r++)
      for (int g = 0; g < W/P; g++) exp_q.push_back(exp_word(r, g));
  endtask

  task automatic send_px(input logic [15:0] fp, input int col, input int row);
    @(posedge clk); #1;
    fp_i = fp; col_i = 16'(col); row_i = 16'(row); valid_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      fp_i    = 16'($urandom);
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) idle($urandom_range(0, 3));
        send_px(fr[r][c], c, r);
      end
    idle(1);
  endtask

  task automatic rand_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case ($urandom_range(0, 2))
          0:       fr[r][c] = 16'($urandom);
          1:       fr[r][c] = {1'b0, 5'($urandom_range(13, 23)), 10'($urandom)};
          default: fr[r][c] = {1'b0, 5'($urandom_range(14, 22)), 10'($urandom) & 10'h3C0};
        endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    ready_i = 1'b1;
    repeat (4) @(posedge clk);
    n = 0;
    while (valid_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", valid_o, 0);
    @(posedge clk); #1;
  endtask

  task automatic compare_q(input string tag);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    fp_i = '0; col_i = '0; row_i = '0;

    // reset state, during and just after reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_sof", sof_o, 0);
    check("rst_eol", eol_o, 0);
    check("rst_ovf", overflow_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_valid", valid_o, 0);
    check("post_rst_data", data_o, 0);

    // directed packing and latency
    send_px(16'h3C00, 0, 0);
    send_px(16'h4000, 1, 0);
    send_px(16'h4200, 2, 0);
    send_px(16'h4400, 3, 0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk); check("lat_c1", valid_o, 0);
    @(negedge clk); check("lat_c2", valid_o, 0);
    @(negedge clk); check("lat_c3", valid_o, 1);
    check("pack_data", data_o, 32'h04030201);
    check("pack_sof", sof_o, 1);
    check("pack_eol", eol_o, 0);
    send_px(16'h4500, 4, 0);
    send_px(16'h4600, 5, 0);
    send_px(16'h4700, 6, 0);
    send_px(16'h4800, 7, 0);
    idle(5);
    check("pack_hold", data_o, 32'h04030201);
    drain();
    exp_q.push_back({1'b1, 1'b0, 32'h04030201});
    exp_q.push_back({1'b0, 1'b1, 32'h08070605});
    compare_q("pack");

    // conversion corner values
    fr[0] = '{16'h3C00, 16'h3E00, 16'h4100, 16'h3800, 16'h5BF8, 16'h5BFC, 16'hBC00, 16'h7C00};
    fr[1] = '{16'h7E00, 16'h4000, 16'h0001, 16'h5C00, 16'h3400, 16'h3A00, 16'h4880, 16'h4B00};
    ready_i = 1'b1;
    send_frame(1'b0);
    drain();
    if (got_q.size() == 4) begin
      check("conv_w0", got_q[0][31:0], 32'h00020201);
      check("conv_w1", got_q[1][31:0], 32'hFF00FFFF);
      check("conv_w2", got_q[2][31:0], 32'hFF000200);
      check("conv_w3", got_q[3][31:0], 32'h0E090100);
    end
    push_frame_exp();
    compare_q("conv");

    // random frames, gapless then with random gaps
    for (int t = 0; t < 3; t++) begin
      rand_frame();
      ready_i = 1'b1;
      send_frame(1'b0);
      drain();
      gl_q = got_q;
      push_frame_exp();
      compare_q($sformatf("rand%0d", t));
      send_frame(1'b1);
      drain();
      exp_q = gl_q;
      compare_q($sformatf("gaps%0d", t));
    end

    // backpressure overflow: 20 words into 16 entries
    rand_frame();
    ready_i = 1'b0;
    repeat (5) send_frame(1'b0);
    idle(5);
    check("bp_ovf", overflow_o, 1);
    check("bp_valid", valid_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stall", {sof_o, eol_o, data_o}, exp_word(0, 0));
    end
    drain();
    repeat (4) push_frame_exp();
    compare_q("bp");
    do_reset();
    @(negedge clk);
    check("bp_ovf_cleared", overflow_o, 0);

    // full FIFO with simultaneous read on the completing cycle
    rand_frame();
    @(posedge clk); #1;
    ready_i = 1'b0;
    repeat (4) send_frame(1'b0);
    idle(5);
    check("full_ovf_pre", overflow_o, 0);
    for (int c = 0; c < P; c++) send_px(fr[0][c], c, 0);
    @(posedge clk); #1; valid_i = 1'b0;
    @(posedge clk); #1; ready_i = 1'b1;
    @(posedge clk); #1; ready_i = 1'b0;
    idle(3);
    check("full_ovf_post", overflow_o, 0);
    drain();
    repeat (4) push_frame_exp();
    exp_q.push_back(exp_word(0, 0));
    compare_q("full_rw");

    // reset in the middle of a word
    ready_i = 1'b1;
    send_px(16'h4000, 0, 0);
    send_px(16'h4000, 1, 0);
    do_reset();
    fr[0][0] = 16'h3C00; fr[0][1] = 16'h4200; fr[0][2] = 16'h4400; fr[0][3] = 16'h4500;
    for (int c = 0; c < P; c++) send_px(fr[0][c], c, 0);
    idle(2);
    drain();
    exp_q.push_back(exp_word(0, 0));
    compare_q("midrst");
    check("midrst_ovf", overflow_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
